// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: BadVAddr, Count, Compare, Status, Cause, EPC.
// Commits exceptions, services MTC0/MFC0/ERET, runs the Count/Compare timer.
module cp0_regfile #(
   parameter logic [31:0] RESET_STATUS = 32'h0040_0000,
   parameter int unsigned COUNT_DIV    = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mtc0_we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [4:0]  raddr,
   output logic [31:0] rdata,
   input  logic        exc_valid,
   input  logic [4:0]  exc_code,
   input  logic        exc_bd,
   input  logic [31:0] exc_pc,
   input  logic        exc_badvaddr_we,
   input  logic [31:0] exc_badvaddr,
   input  logic        eret,
   input  logic [5:0]  hw_int,
   output logic [31:0] status,
   output logic [31:0] cause,
   output logic [31:0] epc,
   output logic        int_pending,
   output logic        timer_int
);

   localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;

   logic [31:0] status_q, cause_q, epc_q, count_q, compare_q, badvaddr_q;
   logic [31:0] status_n, cause_n, epc_n;
   logic        div_q;
   logic        tick;
   logic        we_count, we_compare, we_status, we_cause, we_epc;

   always_comb begin
      we_count   = mtc0_we && (waddr == 5'd9);
      we_compare = mtc0_we && (waddr == 5'd11);
      we_status  = mtc0_we && (waddr == 5'd12);
      we_cause   = mtc0_we && (waddr == 5'd13);
      we_epc     = mtc0_we && (waddr == 5'd14);
   end

   assign tick = (COUNT_DIV == 1) ? 1'b1 : div_q;

   // Field-level merge: exception wins over MTC0/ERET only on the fields it owns.
   always_comb begin
      status_n = status_q;
      if (we_status)
         status_n = (status_q & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
      if (exc_valid)
         status_n[1] = 1'b1;
      else if (eret)
         status_n[1] = 1'b0;

      cause_n = cause_q;
      if (we_cause)
         cause_n[9:8] = wdata[9:8];
      cause_n[15:10] = {hw_int[5] | cause_q[30], hw_int[4:0]};
      if (we_compare)
         cause_n[30] = 1'b0;
      else if ((count_q == compare_q) && (compare_q != '0))
         cause_n[30] = 1'b1;
      if (exc_valid) begin
         cause_n[6:2] = exc_code;
         if (!status_q[1])
            cause_n[31] = exc_bd;
      end

      epc_n = epc_q;
      if (exc_valid) begin
         if (!status_q[1])
            epc_n = exc_bd ? (exc_pc - 32'd4) : exc_pc;
      end else if (we_epc) begin
         epc_n = wdata;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         status_q   <= RESET_STATUS;
         cause_q    <= '0;
         epc_q      <= '0;
         badvaddr_q <= '0;
         count_q    <= '0;
         compare_q  <= '0;
         div_q      <= 1'b0;
      end else begin
         status_q <= status_n;
         cause_q  <= cause_n;
         epc_q    <= epc_n;
         div_q    <= ((COUNT_DIV == 1) || we_count) ? 1'b0 : ~div_q;
         if (we_count)
            count_q <= wdata;
         else if (tick)
            count_q <= count_q + 32'd1;
         if (we_compare)
            compare_q <= wdata;
         if (exc_valid && exc_badvaddr_we)
            badvaddr_q <= exc_badvaddr;
      end
   end

   always_comb begin
      case (raddr)
         5'd8:    rdata = badvaddr_q;
         5'd9:    rdata = count_q;
         5'd11:   rdata = compare_q;
         5'd12:   rdata = status_q;
         5'd13:   rdata = cause_q;
         5'd14:   rdata = epc_q;
         default: rdata = '0;
      endcase
   end

   assign status      = status_q;
   assign cause       = cause_q;
   assign epc         = epc_q;
   assign timer_int   = cause_q[30];
   assign int_pending = status_q[0] & ~status_q[1] & (|(cause_q[15:8] & status_q[15:8]));

endmodule
